// File: rtl/cp0_exc_ctrl.sv
// CP0 exception sequencer: owns Status/Cause/EPC and runs the
// capture -> flush -> redirect sequence for exceptions and ERET.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pendingexception,
    input  logic [4:0]  exccode,
    input  logic [7:0]  interrupts,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        iec,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        exc_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] FLUSH_LAST = FLUSH_CYCLES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  status_q, status_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] rpc_q, rpc_d;
    logic        ack_q, ack_d;

    logic take_exc, take_eret, take_wr;

    // Exception beats ERET beats MTC0; nothing is accepted outside IDLE.
    assign take_exc  = (state_q == IDLE) && pendingexception;
    assign take_eret = (state_q == IDLE) && !pendingexception && eret;
    assign take_wr   = (state_q == IDLE) && !pendingexception && !eret && cp0_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            status_q <= 6'd0;
            bd_q     <= 1'b0;
            code_q   <= 5'd0;
            epc_q    <= 32'd0;
            target_q <= 32'd0;
            rpc_q    <= 32'd0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            target_q <= target_d;
            rpc_q    <= rpc_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (take_exc || take_eret) begin
                    state_d = FLUSH;
                    cnt_d   = 4'd1;
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        status_d = status_q;
        bd_d     = bd_q;
        code_d   = code_q;
        epc_d    = epc_q;
        target_d = target_q;
        ack_d    = take_exc;
        // redirect_pc only moves when the redirect cycle begins
        rpc_d    = (state_q == FLUSH && state_d == REDIRECT) ? target_q : rpc_q;
        if (take_exc) begin
            epc_d    = exc_bd ? (exc_pc - 32'd4) : exc_pc;
            bd_d     = exc_bd;
            code_d   = exccode;
            status_d = {status_q[3:0], 2'b00};
            target_d = EXC_VECTOR;
        end else if (take_eret) begin
            status_d = {status_q[5:4], status_q[5:2]};
            target_d = epc_q;
        end else if (take_wr) begin
            if (cp0_waddr == 5'd12) status_d = cp0_wdata[5:0];
            if (cp0_waddr == 5'd14) epc_d = cp0_wdata;
        end
    end

    always_comb begin
        flush       = (state_q == FLUSH);
        pc_redirect = (state_q == REDIRECT);
        busy        = (state_q != IDLE);
        exc_ack     = ack_q;
        redirect_pc = rpc_q;
        iec         = status_q[0];
        case (cp0_raddr)
            5'd12:   cp0_rdata = {26'd0, status_q};
            5'd13:   cp0_rdata = {bd_q, 15'd0, interrupts, 1'b0, code_q, 2'b00};
            5'd14:   cp0_rdata = epc_q;
            default: cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exception/ERET sequencing, priority,
// held requests and mid-sequence reset, with hand-computed expectations.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pendingexception;
    logic [4:0]  exccode;
    logic [7:0]  interrupts;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        iec;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        exc_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl #(
        .EXC_VECTOR  (32'h8000_0080),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pendingexception(pendingexception),
        .exccode         (exccode),
        .interrupts      (interrupts),
        .exc_pc          (exc_pc),
        .exc_bd          (exc_bd),
        .eret            (eret),
        .cp0_we          (cp0_we),
        .cp0_waddr       (cp0_waddr),
        .cp0_wdata       (cp0_wdata),
        .cp0_raddr       (cp0_raddr),
        .cp0_rdata       (cp0_rdata),
        .iec             (iec),
        .flush           (flush),
        .pc_redirect     (pc_redirect),
        .redirect_pc     (redirect_pc),
        .exc_ack         (exc_ack),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        cp0_raddr = addr;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; pendingexception = 1'b0; exccode = 5'd0; interrupts = 8'd0;
        exc_pc = 32'd0; exc_bd = 1'b0; eret = 1'b0; cp0_we = 1'b0;
        cp0_waddr = 5'd0; cp0_wdata = 32'd0; cp0_raddr = 5'd0;
        tick(); tick();
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_iec", {31'd0, iec}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        rd(5'd12, "rst_status", 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic exception, no delay slot
        pendingexception = 1'b1; exccode = 5'd8; exc_pc = 32'h0040_0010; exc_bd = 1'b0;
        tick();
        pendingexception = 1'b0;
        check("t1_ack_n1", {31'd0, exc_ack}, 32'd1);
        check("t1_flush_n1", {31'd0, flush}, 32'd1);
        check("t1_redir_n1", {31'd0, pc_redirect}, 32'd0);
        rd(5'd14, "t1_epc", 32'h0040_0010);
        rd(5'd13, "t1_cause", 32'h0000_0020);
        tick();
        check("t1_ack_n2", {31'd0, exc_ack}, 32'd0);
        check("t1_flush_n2", {31'd0, flush}, 32'd1);
        tick();
        check("t1_flush_n3", {31'd0, flush}, 32'd0);
        check("t1_redir_n3", {31'd0, pc_redirect}, 32'd1);
        check("t1_rpc_n3", redirect_pc, 32'h8000_0080);
        tick();
        check("t1_busy_n4", {31'd0, busy}, 32'd0);
        check("t1_redir_n4", {31'd0, pc_redirect}, 32'd0);
        check("t1_rpc_hold", redirect_pc, 32'h8000_0080);

        // MTC0 Status, then exception in a delay slot at PC 0
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0001;
        tick();
        cp0_we = 1'b0;
        rd(5'd12, "t2_status_wr", 32'h0000_0001);
        check("t2_iec_wr", {31'd0, iec}, 32'd1);
        pendingexception = 1'b1; exccode = 5'd4; exc_pc = 32'h0; exc_bd = 1'b1;
        tick();
        pendingexception = 1'b0; exc_bd = 1'b0;
        rd(5'd14, "t2_epc", 32'hFFFF_FFFC);
        rd(5'd13, "t2_cause", 32'h8000_0010);
        rd(5'd12, "t2_status", 32'h0000_0004);
        check("t2_iec", {31'd0, iec}, 32'd0);
        tick(); tick(); tick();
        check("t2_idle", {31'd0, busy}, 32'd0);

        // ERET pops the stack and returns to EPC
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd(5'd12, "t3_status", 32'h0000_0001);
        check("t3_iec", {31'd0, iec}, 32'd1);
        check("t3_no_ack", {31'd0, exc_ack}, 32'd0);
        check("t3_flush", {31'd0, flush}, 32'd1);
        tick(); tick();
        check("t3_redir", {31'd0, pc_redirect}, 32'd1);
        check("t3_rpc", redirect_pc, 32'hFFFF_FFFC);
        tick();

        // Exception, ERET and MTC0 in the same cycle
        pendingexception = 1'b1; exccode = 5'd12; exc_pc = 32'h0000_0100; exc_bd = 1'b0;
        eret = 1'b1; cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1234;
        tick();
        pendingexception = 1'b0; eret = 1'b0; cp0_we = 1'b0;
        check("t4_ack", {31'd0, exc_ack}, 32'd1);
        rd(5'd14, "t4_epc", 32'h0000_0100);
        rd(5'd12, "t4_status", 32'h0000_0004);
        tick(); tick();
        check("t4_redir", {31'd0, pc_redirect}, 32'd1);
        check("t4_rpc", redirect_pc, 32'h8000_0080);
        tick();

        // pendingexception held high: one ack per sequence, recapture at N+4
        pendingexception = 1'b1; exccode = 5'd0; exc_pc = 32'h0000_0200;
        tick();
        check("t5_ack_n1", {31'd0, exc_ack}, 32'd1);
        tick();
        check("t5_ack_n2", {31'd0, exc_ack}, 32'd0);
        tick();
        check("t5_ack_n3", {31'd0, exc_ack}, 32'd0);
        check("t5_redir_n3", {31'd0, pc_redirect}, 32'd1);
        tick();
        check("t5_ack_n4", {31'd0, exc_ack}, 32'd0);
        check("t5_busy_n4", {31'd0, busy}, 32'd0);
        tick();
        pendingexception = 1'b0;
        check("t5_ack_n5", {31'd0, exc_ack}, 32'd1);
        tick();
        check("t5_in_flush", {31'd0, flush}, 32'd1);

        // Reset in the middle of FLUSH
        interrupts = 8'hA5;
        rst_n = 1'b0;
        #1;
        check("t6_flush_rst", {31'd0, flush}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_rpc_rst", redirect_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_redir", {31'd0, pc_redirect}, 32'd0);
            tick();
        end
        rd(5'd12, "t6_status", 32'd0);
        rd(5'd14, "t6_epc", 32'd0);
        rd(5'd13, "t6_cause", 32'h0000_A500);
        rd(5'd7, "t6_unmapped", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception sequencing controller for coprocessor 0. Takes the prioritized `pendingexception`/`exccode` pair from the CP0 exception decoder, and owns the EPC, Cause and Status registers. Runs the flush/redirect sequence into the pipeline and handles ERET. It also supplies `iec` back to the decoder, closing the interrupt-enable loop.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h8000_0080, general exception handler address.
- `FLUSH_CYCLES`, 2, cycles `flush` stays high per sequence; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pendingexception`  in  1  exception request from the decoder.
- `exccode`  in  5  cause code accompanying `pendingexception`.
- `interrupts`  in  8  raw interrupt lines; reflected live in Cause.IP.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_bd`  in  1  faulting instruction is in a branch delay slot.
- `eret`  in  1  ERET instruction at commit.
- `cp0_we`  in  1  MTC0 write strobe.
- `cp0_waddr`  in  5  MTC0 register number.
- `cp0_wdata`  in  32  MTC0 data.
- `cp0_raddr`  in  5  MFC0 register number.
- `cp0_rdata`  out  32  MFC0 data (combinational).
- `iec`  out  1  Status.IEc, current interrupt enable.
- `flush`  out  1  kill all in-flight pipeline instructions.
- `pc_redirect`  out  1  one-cycle load of `redirect_pc` into the fetch PC.
- `redirect_pc`  out  32  target for `pc_redirect`.
- `exc_ack`  out  1  one-cycle pulse when an exception is captured.
- `busy`  out  1  high whenever state != IDLE.

## Operation
Registers:
- Status[5:0] = {KUo, IEo, KUp, IEp, KUc, IEc}; other bits read 0.
- Cause = {BD[31], 15'b0, IP[15:8] = `interrupts`, 1'b0, ExcCode[6:2], 2'b0}.
- EPC[31:0].
- Read map: 12 = Status, 13 = Cause, 14 = EPC, all other addresses read 0.

Reset: state IDLE; Status, Cause.BD, Cause.ExcCode, EPC and the counter are 0. `flush`, `pc_redirect`, `exc_ack`, `busy` and `iec` are 0; `redirect_pc` is 0.

States:
- **IDLE**
  - `pendingexception` = 1: capture.
    - EPC ← `exc_bd` ? `exc_pc` − 4 (mod 2^32) : `exc_pc`.
    - Cause.BD ← `exc_bd`; Cause.ExcCode ← `exccode`.
    - Status[5:0] ← {Status[3:0], 2'b00}, i.e. push the stack.
    - Latch target = `EXC_VECTOR`; pulse `exc_ack`; go to FLUSH.
  - Otherwise, `eret` = 1:
    - Status[5:0] ← {Status[5:4], Status[5:2]}, i.e. pop the stack.
    - Latch target = EPC; go to FLUSH.
  - Otherwise, `cp0_we` = 1: MTC0 write.
    - Addr 12 writes Status[5:0] ← `cp0_wdata`[5:0].
    - Addr 14 writes EPC.
    - Cause and all other addresses ignore writes.
- **FLUSH**: `flush` = 1; counter counts up to `FLUSH_CYCLES`, then go to REDIRECT.
- **REDIRECT**: `pc_redirect` = 1, `redirect_pc` = latched target; go to IDLE.

Priority and masking:
- Exception > ERET > MTC0 in the same IDLE cycle; the losers are dropped, with no side effects.
- Outside IDLE, `pendingexception`, `eret` and `cp0_we` are all ignored. Those instructions are being flushed.

## Timing
Exception or ERET accepted on edge N (IDLE):
- `exc_ack` is high in cycle N+1 (exceptions only).
- `flush` is high in cycles N+1 .. N+`FLUSH_CYCLES`.
- `pc_redirect` is high in cycle N+`FLUSH_CYCLES`+1.
- IDLE again, and able to accept a new event, at N+`FLUSH_CYCLES`+2.

Register timing:
- EPC, Cause and Status are visible on `cp0_rdata` from cycle N+1.
- `iec` changes in cycle N+1 (0 after an exception, IEp after ERET).
- `redirect_pc` holds its last target when `pc_redirect` = 0.
- `flush` and `pc_redirect` are never high in the same cycle.

Other rules:
- An MTC0 write in IDLE takes effect the next cycle. MFC0 reflects state combinationally.
- Reset asserted mid-sequence immediately forces IDLE with all outputs at their reset values; the aborted sequence produces no redirect.
- Nested exception (a handler faults with IEc already 0): accepted normally and pushes the stack again, so KUo/IEo are overwritten.

## Test plan
- Reset release; `pendingexception` = 1, `exccode` = 8, `exc_pc` = 32'h0040_0010, `exc_bd` = 0 at cycle N:
  - `exc_ack` at N+1.
  - `flush` at N+1..N+2.
  - `pc_redirect` at N+3 with `redirect_pc` = 32'h8000_0080.
  - EPC reads 32'h0040_0010; Cause reads 32'h0000_0020.
- Status = 6'b000001 via MTC0; exception with `exc_bd` = 1, `exc_pc` = 32'h0:
  - EPC = 32'hFFFF_FFFC, Cause[31] = 1.
  - Status = 6'b000100, `iec` = 0.
- Then `eret`:
  - Status = 6'b000001, `iec` = 1.
  - `pc_redirect` with `redirect_pc` = 32'hFFFF_FFFC, 3 cycles after acceptance.
- Same-cycle `pendingexception`, `eret` and `cp0_we` (addr 14, 32'h1234):
  - The exception sequence runs and redirects to the vector.
  - EPC = `exc_pc`, not 32'h1234.
- `pendingexception` held high throughout a sequence:
  - Exactly one `exc_ack` per sequence.
  - The next capture happens at N+4 (`FLUSH_CYCLES` = 2).
- `rst_n` low during FLUSH:
  - `flush` drops immediately; no `pc_redirect` follows.
  - Status, EPC and Cause read 0; `interrupts` = 8'hA5 reads back as Cause[15:8] = 8'hA5.
